poly_mul_q_seq: RTL
===================

Name: poly_mul_q_seq

Overview:
- Parametrised sequential multiplier for NTRU-HRSS ring arithmetic. Computes e = c·h mod (x^N − 1) in R_q; optionally reduces the result into S_q by subtracting the top coefficient.
- h is loaded in parallel. c coefficients stream in one per beat over a valid/ready handshake.
- Successor to the fixed N=701, q=2^13, S_q-only multiplier. Adds:
  - width and degree parameters
  - a per-operation mode
  - a start/busy/done handshake
  - input back-pressure
  - a proper asynchronous reset

Parameters:
- N, 701, polynomial length (coefficient count). N ≥ 3.
- LOGQ, 13, coefficient width. q = 2^LOGQ, so all arithmetic is mod 2^LOGQ by truncation.
- CW, $clog2(N+1), beat-counter width (derived; do not override).

Ports:
- clk, in, 1, clock. All state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, operation request. Sampled only in IDLE.
- mode, in, 1, reduction mode: 0 = R_q, 1 = S_q. Latched on start.
- h, in, N*LOGQ, operand h. Coefficient i is at bits [i*LOGQ +: LOGQ]. Latched on start.
- c_data, in, LOGQ, one coefficient of c, unsigned mod q (ternary −1 is encoded as q−1).
- c_valid, in, 1, c_data is valid.
- c_ready, out, 1, block accepts a c beat this cycle.
- busy, out, 1, operation in progress.
- done, out, 1, one-cycle pulse when result is updated.
- result, out, N*LOGQ, product. Coefficient i is at bits [i*LOGQ +: LOGQ].

Behaviour:
- Reset (rst=0, asynchronous):
  - state → IDLE
  - accumulator, h register, mode register, beat counter and result → 0
  - c_ready, busy, done → 0
  - Takes effect mid-operation with no completion and no done pulse.
- States: IDLE, RUN, REDUCE.
- IDLE:
  - start=1 at an edge → latch h and mode, clear accumulator and counter, go to RUN.
  - start=0 → stay in IDLE.
- RUN:
  - c_ready = 1 (combinational, state==RUN).
  - Beat = c_valid && c_ready at an edge. Beats deliver c in descending index order, c_{N-1} first and c_0 last.
  - Per beat (Horner step, all indices in parallel): acc[i] ← acc[(i−1) mod N] + c_data·h[i] mod 2^LOGQ. The product is LOGQ×LOGQ truncated to LOGQ bits.
  - No beat → acc and counter hold. Stalls of any length are legal.
  - On the Nth beat → go to REDUCE.
- REDUCE (exactly one cycle, c_ready = 0):
  - mode=0: result[i] ← acc[i] for all i.
  - mode=1: result[i] ← acc[i] − acc[N−1] mod 2^LOGQ for i < N−1, and result[N−1] ← 0.
  - done ← 1 (registered, high for exactly one cycle, coincident with the new result). Go to IDLE.
- busy = (state != IDLE). busy is low in the cycle done is high.
- Minimum latency: start edge k, beats at edges k+1..k+N, result and done update at edge k+N+1.
- result holds its value from REDUCE until the next REDUCE or reset. It is not cleared on start.
- start while busy: ignored. No restart, no latch.
- start sampled in the same cycle done is high: accepted (state is IDLE).
- c_valid in IDLE or REDUCE: ignored. No beat is counted.
- h and mode changing during RUN: no effect (latched copies are used).

Test Plan (N=5, LOGQ=4, h = [h0..h4] = [1,2,3,4,5]):
- mode=0, stream c4..c0 = 0,0,0,1,0 (c = x), c_valid held high → done at edge k+6; result = [5,1,2,3,4].
- mode=1, same c → result = [1,13,14,15,0].
- mode=0, stream 1,1,1,1,1 → result = [15,15,15,15,15]. Repeat with mode=1 → result = [0,0,0,0,0].
- mode=0, c = 15 (i.e. −1 at c0; stream 0,0,0,0,15) with c_valid dropped for 3 cycles after the 2nd beat → result = [15,14,13,12,11]; done at edge k+9; c_ready high throughout RUN; counter frozen during the stall.
- Drive rst=0 asynchronously after the 3rd beat → busy, c_ready and done drop immediately and result = 0. Release reset, run the first scenario → result = [5,1,2,3,4], with no stale accumulation.
- Pulse start again during RUN with a different h → ignored; the original result is produced. Assert start in the done cycle → new operation begins and busy goes high at the next edge.

Source files
------------

// File: rtl/poly_mul_q_seq.sv
// Sequential multiplier e = c*h mod (x^N - 1) over Z_(2^LOGQ), with optional S_q reduction.
// h is latched in parallel; c streams in descending index order, one Horner step per beat.
module poly_mul_q_seq #(
  parameter int unsigned N    = 701,
  parameter int unsigned LOGQ = 13,
  parameter int unsigned CW   = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [N*LOGQ-1:0]   h,
  input  logic [LOGQ-1:0]     c_data,
  input  logic                c_valid,
  output logic                c_ready,
  output logic                busy,
  output logic                done,
  output logic [N*LOGQ-1:0]   result
);

  typedef enum logic [1:0] {StIdle, StRun, StReduce} state_e;

  state_e              state_q, state_d;
  logic [N*LOGQ-1:0]   acc_q;
  logic [N*LOGQ-1:0]   h_q;
  logic [N*LOGQ-1:0]   result_q;
  logic                mode_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q;
  logic                beat;
  logic                last_beat;

  assign c_ready   = (state_q == StRun);
  assign beat      = c_valid && c_ready;
  assign last_beat = beat && (cnt_q == CW'(N - 1));
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign result    = result_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (last_beat) state_d = StReduce;
      StReduce: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      h_q      <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            h_q    <= h;
            mode_q <= mode;
            acc_q  <= '0;
            cnt_q  <= '0;
          end
        end
        StRun: begin
          if (beat) begin
            // Multiply-by-x (cyclic rotate) plus c_j*h, truncated to LOGQ bits.
            for (int unsigned i = 0; i < N; i++) begin
              acc_q[i*LOGQ +: LOGQ] <= acc_q[((i + N - 1) % N)*LOGQ +: LOGQ]
                                       + c_data * h_q[i*LOGQ +: LOGQ];
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReduce: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (!mode_q) begin
              result_q[i*LOGQ +: LOGQ] <= acc_q[i*LOGQ +: LOGQ];
            end else if (i == N - 1) begin
              result_q[i*LOGQ +: LOGQ] <= '0;
            end else begin
              result_q[i*LOGQ +: LOGQ] <= acc_q[i*LOGQ +: LOGQ]
                                          - acc_q[(N-1)*LOGQ +: LOGQ];
            end
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
